// File: rtl/dbus_periph_bridge.sv
// CPU data-bus to peripheral bridge: stalls the CPU on accesses that fall in the
// peripheral window, issues one registered request and waits for ack or timeout.
module dbus_periph_bridge #(
  parameter logic [31:0] PBASE   = 32'hFF20_0000,
  parameter logic [31:0] PSIZE   = 32'h0000_1000,
  parameter int          TIMEOUT = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        DReadEnable,
  input  logic        DWriteEnable,
  input  logic [3:0]  DByteEnable,
  input  logic [31:0] DAddress,
  input  logic [31:0] DWriteData,
  output logic [31:0] DReadData,
  output logic        oStall,
  output logic        oPReq,
  output logic        oPWe,
  output logic [31:0] oPAddr,
  output logic [3:0]  oPBe,
  output logic [31:0] oPWData,
  input  logic        iPAck,
  input  logic [31:0] iPRData,
  output logic        oBusError,
  output logic [7:0]  oErrCount
);

  // state  | meaning
  // S_IDLE | no access in flight; stall follows a window hit combinationally
  // S_REQ  | request presented to peripheral, waiting for ack or timeout
  // S_DONE | one cycle: CPU released, load data presented
  // S_ERR  | one cycle: CPU released with 32'hDEAD_BEEF, error recorded
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] offset;
  logic        hit;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;
  logic        timed_out;

  // Offset-based compare avoids overflow when PBASE+PSIZE wraps past 2^32.
  assign offset    = DAddress - PBASE;
  assign hit       = (DReadEnable | DWriteEnable) && (DAddress >= PBASE) && (offset < PSIZE);
  assign timed_out = (state == S_REQ) && !iPAck && (cnt == CNT_LAST);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (hit) state_nxt = S_REQ;
      S_REQ: begin
        if (iPAck)                state_nxt = S_DONE;
        else if (cnt == CNT_LAST) state_nxt = S_ERR;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    oPReq     = (state == S_REQ);
    oStall    = iRST && ((state == S_REQ) || ((state == S_IDLE) && hit));
    DReadData = 32'h0;
    if (iRST) begin
      if (state == S_DONE)     DReadData = rdata_q;
      else if (state == S_ERR) DReadData = 32'hDEAD_BEEF;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oPWe    <= 1'b0;
      oPAddr  <= 32'h0;
      oPBe    <= 4'h0;
      oPWData <= 32'h0;
      cnt     <= 8'h0;
      rdata_q <= 32'h0;
    end else begin
      if ((state == S_IDLE) && hit) begin
        oPAddr  <= offset & 32'hFFFF_FFFC;
        oPBe    <= DByteEnable;
        oPWData <= DWriteData;
        oPWe    <= DWriteEnable;
        cnt     <= 8'h0;
      end else if (state == S_REQ) begin
        cnt <= cnt + 8'd1;
      end
      if ((state == S_REQ) && iPAck)
        rdata_q <= oPWe ? 32'h0 : iPRData;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oBusError <= 1'b0;
      oErrCount <= 8'h0;
    end else if (timed_out) begin
      oBusError <= 1'b1;
      if (oErrCount != 8'hFF) oErrCount <= oErrCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_dbus_periph_bridge.sv
// Directed bench for dbus_periph_bridge: hits, misses, timeouts, error saturation,
// ack boundary, reset abort and back-to-back accesses.
module tb_dbus_periph_bridge;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        DReadEnable = 1'b0;
  logic        DWriteEnable = 1'b0;
  logic [3:0]  DByteEnable = 4'h0;
  logic [31:0] DAddress = 32'h0;
  logic [31:0] DWriteData = 32'h0;
  logic [31:0] DReadData;
  logic        oStall;
  logic        oPReq;
  logic        oPWe;
  logic [31:0] oPAddr;
  logic [3:0]  oPBe;
  logic [31:0] oPWData;
  logic        iPAck = 1'b0;
  logic [31:0] iPRData = 32'h0;
  logic        oBusError;
  logic [7:0]  oErrCount;

  int errors = 0;
  int checks = 0;

  dbus_periph_bridge dut (
    .iCLK(iCLK), .iRST(iRST),
    .DReadEnable(DReadEnable), .DWriteEnable(DWriteEnable),
    .DByteEnable(DByteEnable), .DAddress(DAddress), .DWriteData(DWriteData),
    .DReadData(DReadData), .oStall(oStall),
    .oPReq(oPReq), .oPWe(oPWe), .oPAddr(oPAddr), .oPBe(oPBe), .oPWData(oPWData),
    .iPAck(iPAck), .iPRData(iPRData),
    .oBusError(oBusError), .oErrCount(oErrCount)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle_bus();
    DReadEnable  = 1'b0;
    DWriteEnable = 1'b0;
    DByteEnable  = 4'h0;
    DAddress     = 32'h0;
    DWriteData   = 32'h0;
  endtask

  initial begin
    int n;

    // reset with a hit presented: stall and load data must stay low
    DReadEnable = 1'b1;
    DAddress    = 32'hFF20_0010;
    #22;
    chk("rst_stall", oStall, 0);
    chk("rst_rdata", DReadData, 0);
    chk("rst_preq", oPReq, 0);
    chk("rst_paddr", oPAddr, 0);
    chk("rst_buserr", oBusError, 0);
    chk("rst_errcnt", oErrCount, 0);
    idle_bus();
    step();
    iRST = 1'b1;
    step();

    // read hit, ack on third REQ cycle
    DReadEnable = 1'b1;
    DAddress    = 32'hFF20_0010;
    #1;
    chk("rd_hit_stall", oStall, 1);
    chk("rd_hit_preq", oPReq, 0);
    step();
    chk("rd_req1_preq", oPReq, 1);
    chk("rd_req1_stall", oStall, 1);
    chk("rd_paddr", oPAddr, 32'h10);
    chk("rd_pwe", oPWe, 0);
    step();
    chk("rd_req2_stall", oStall, 1);
    step();
    iPAck = 1'b1; iPRData = 32'h1234_5678;
    chk("rd_req3_stall", oStall, 1);
    step();
    iPAck = 1'b0; iPRData = 32'h0;
    chk("rd_done_stall", oStall, 0);
    chk("rd_done_preq", oPReq, 0);
    chk("rd_done_data", DReadData, 32'h1234_5678);
    idle_bus();
    step();
    chk("rd_after_data", DReadData, 0);

    // write hit at last word of window, ack on first REQ cycle
    DWriteEnable = 1'b1; DAddress = 32'hFF20_0FFE;
    DByteEnable  = 4'b1100; DWriteData = 32'hAABB_0000;
    step();
    chk("wr_paddr", oPAddr, 32'hFFC);
    chk("wr_pbe", oPBe, 4'b1100);
    chk("wr_pwe", oPWe, 1);
    chk("wr_pwdata", oPWData, 32'hAABB_0000);
    iPAck = 1'b1; iPRData = 32'h5555_5555;
    step();
    iPAck = 1'b0;
    chk("wr_done_stall", oStall, 0);
    chk("wr_done_data", DReadData, 0);
    idle_bus();
    step();

    // misses, plus a stray ack while idle
    DReadEnable = 1'b1; DAddress = 32'h1001_0000;
    #1;
    chk("miss_lo_stall", oStall, 0);
    step();
    chk("miss_lo_preq", oPReq, 0);
    chk("miss_lo_data", DReadData, 0);
    DAddress = 32'hFF20_1000;
    #1;
    chk("miss_end_stall", oStall, 0);
    step();
    chk("miss_end_preq", oPReq, 0);
    DAddress = 32'hFF1F_FFFC;
    #1;
    chk("miss_below_stall", oStall, 0);
    idle_bus();
    iPAck = 1'b1; iPRData = 32'hCAFE_0001;
    step();
    iPAck = 1'b0;
    step();
    chk("stray_ack_preq", oPReq, 0);
    chk("stray_ack_data", DReadData, 0);

    // timeout: count REQ cycles
    DReadEnable = 1'b1; DAddress = 32'hFF20_0004;
    step();
    n = 0;
    while (oPReq && n < 100) begin
      n++;
      step();
    end
    chk("to_req_cycles", n, 16);
    chk("to_err_data", DReadData, 32'hDEAD_BEEF);
    chk("to_err_stall", oStall, 0);
    chk("to_buserr", oBusError, 1);
    chk("to_errcnt", oErrCount, 1);
    idle_bus();
    step();
    chk("to_idle_data", DReadData, 0);

    // ack on the 16th REQ cycle wins over timeout
    DReadEnable = 1'b1; DAddress = 32'hFF20_0008;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("last_preq", oPReq, 1);
    iPAck = 1'b1; iPRData = 32'h0BAD_F00D;
    step();
    iPAck = 1'b0;
    chk("last_done_data", DReadData, 32'h0BAD_F00D);
    chk("last_errcnt", oErrCount, 1);
    idle_bus();
    step();

    // both enables -> write; then back-to-back hit
    DReadEnable = 1'b1; DWriteEnable = 1'b1; DAddress = 32'hFF20_0100;
    DByteEnable = 4'hF; DWriteData = 32'h1111_2222;
    step();
    chk("both_pwe", oPWe, 1);
    iPAck = 1'b1;
    step();
    iPAck = 1'b0;
    chk("both_done_stall", oStall, 0);
    idle_bus();
    step();
    DReadEnable = 1'b1; DAddress = 32'hFF20_0020;
    #1;
    chk("b2b_idle_preq", oPReq, 0);
    step();
    chk("b2b_preq", oPReq, 1);
    chk("b2b_paddr", oPAddr, 32'h20);
    chk("b2b_pwe", oPWe, 0);

    // reset mid-REQ: outputs drop at once, later ack ignored
    #2;
    iRST = 1'b0;
    #1;
    chk("rst_mid_preq", oPReq, 0);
    chk("rst_mid_stall", oStall, 0);
    chk("rst_mid_errcnt", oErrCount, 0);
    idle_bus();
    step();
    #2;
    iRST = 1'b1;
    step();
    iPAck = 1'b1; iPRData = 32'h7777_7777;
    step();
    iPAck = 1'b0;
    step();
    chk("rst_ack_preq", oPReq, 0);
    chk("rst_ack_data", DReadData, 0);
    chk("rst_ack_buserr", oBusError, 0);

    // repeated timeouts: each takes IDLE + 16 REQ + ERR = 18 cycles
    DReadEnable = 1'b1; DAddress = 32'hFF20_0040;
    for (int i = 0; i < 10 * 18; i++) step();
    chk("sat_cnt10", oErrCount, 10);
    for (int i = 0; i < 290 * 18; i++) step();
    chk("sat_cnt300", oErrCount, 255);
    idle_bus();
    step();
    chk("sat_buserr", oBusError, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
